// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and helpers for the UART transmit arbiter.
//   arb_state_t : arbiter FSM states (HDR only when UART_ARB_CHAN_HDR_EN is defined)
//   HDR_TAG     : upper nibble of the per-packet channel header (UART_ARB_CHAN_HDR_EN only)
//   rr_pick     : rotating-priority search, returns {found, idx[3:0]}
// Optional macro: UART_ARB_CHAN_HDR_EN
package uart_arb_pkg;

`ifdef UART_ARB_CHAN_HDR_EN
  typedef enum logic [2:0] {IDLE, HDR, FETCH, START, WAIT} arb_state_t;
  localparam logic [3:0] HDR_TAG = 4'hA;
`else
  typedef enum logic [2:0] {IDLE, FETCH, START, WAIT} arb_state_t;
`endif

  // Scan ptr, ptr+1, ... modulo n (n <= 16) and return the first set bit.
  // Result packs the found flag above a 4-bit index.
  function automatic logic [4:0] rr_pick(input logic [15:0] valid,
                                         input logic [3:0]  ptr,
                                         input int unsigned n);
    logic       found;
    logic [3:0] idx;
    logic [4:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      cand = 5'(ptr) + 5'(k);
      if (cand >= 5'(n)) cand = cand - 5'(n);
      if ((k < n) && !found && valid[cand[3:0]]) begin
        found = 1'b1;
        idx   = cand[3:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick over NUM_REQ request lines.
//   valid : request lines
//   ptr   : registered highest-priority index
//   idx   : first requesting index at or after ptr (wrapping)
//   found : at least one request is present
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [15:0] valid_w;
  logic [3:0]  ptr_w;

  assign valid_w = 16'(valid);
  assign ptr_w   = 4'(ptr);

  assign idx   = IDX_W'(rr_pick(valid_w, ptr_w, NUM_REQ));
  assign found = 1'(rr_pick(valid_w, ptr_w, NUM_REQ) >> 4);

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte-stream requesters,
// round-robin at packet granularity (owner keeps the line until its last byte
// has fully left).
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/data/last/ready : per-requester byte handshake (data i at [8i+7:8i])
//   tx_start, tx_data : drive uart_tx start / data_in
//   tx_active         : uart_tx active
//   grant_idx, busy   : current owner (valid while busy) and packet-in-progress
// Optional macro: UART_ARB_CHAN_HDR_EN prefixes each packet with {4'hA, owner}.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_active,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy
);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             last_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    next_ptr = grant_idx + 1'b1;
    if (grant_idx == IDX_W'(NUM_REQ - 1)) next_ptr = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      last_q    <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        // tx_active must be low so a frame left over from before a reset is
        // never overlapped.
        IDLE: begin
          if (pick_found && !tx_active) begin
            grant_idx <= pick_idx;
            busy      <= 1'b1;
`ifdef UART_ARB_CHAN_HDR_EN
            state     <= HDR;
`else
            state     <= FETCH;
`endif
          end
        end
`ifdef UART_ARB_CHAN_HDR_EN
        HDR: begin
          tx_data  <= {HDR_TAG, 4'(grant_idx)};
          last_q   <= 1'b0;
          tx_start <= 1'b1;
          state    <= START;
        end
`endif
        FETCH: begin
          if (req_valid[grant_idx]) begin
            req_ready[grant_idx] <= 1'b1;
            tx_data  <= req_data[{grant_idx, 3'b000} +: 8];
            last_q   <= req_last[grant_idx];
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        // start is held until uart_tx acknowledges, which rides over its
        // cleanup cycle where start is ignored.
        START: begin
          if (tx_active) begin
            tx_start <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!tx_active) begin
            if (last_q) begin
              rr_ptr <= next_ptr;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              state  <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CPB     = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_active = 1'b0;
  logic [IDX_W-1:0]     grant_idx;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_active (tx_active),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  // Behavioural uart_tx: start sampled when idle, active the next cycle,
  // 10 bits of CPB clocks each, then one cleanup cycle ignoring start.
  logic [9:0] u_frame = '1;
  logic [3:0] u_bit   = '0;
  logic [3:0] u_cnt   = '0;
  logic       u_clean = 1'b0;
  logic       txd;

  always @(posedge clk) begin
    if (tx_active) begin
      if (u_cnt == 4'(CPB - 1)) begin
        u_cnt <= '0;
        if (u_bit == 4'd9) begin
          tx_active <= 1'b0;
          u_clean   <= 1'b1;
        end else begin
          u_bit <= u_bit + 1'b1;
        end
      end else begin
        u_cnt <= u_cnt + 1'b1;
      end
    end else if (u_clean) begin
      u_clean <= 1'b0;
    end else if (tx_start) begin
      u_frame   <= {1'b1, tx_data, 1'b0};
      u_bit     <= '0;
      u_cnt     <= '0;
      tx_active <= 1'b1;
    end
  end
  assign txd = tx_active ? u_frame[u_bit] : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester side: per-requester byte queues {last, data}
  logic [8:0]  rq  [NUM_REQ][$];
  logic [7:0]  pkt [NUM_REQ][$];
  int unsigned stall [NUM_REQ];
  logic [NUM_REQ-1:0] hs;

  // Scoreboard
  logic [7:0] exp_line [$];
  logic [9:0] exp_hs   [$];   // {idx, data}
  int unsigned m_ptr = 0;

  // Driver: holds valid/data until handshake, random gaps between bytes.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) stall[i] = 0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] && rq[i].size() > 0) begin
          void'(rq[i].pop_front());
          stall[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 50) : $urandom_range(0, 2);
        end else if (stall[i] > 0) begin
          stall[i]--;
        end
        if (rq[i].size() > 0 && stall[i] == 0) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i]       = rq[i][0][8];
        end else begin
          req_valid[i]      = 1'b0;
          req_last[i]       = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
    end
  end

  // Handshake monitor
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst && req_ready != '0) begin
        if (exp_hs.size() == 0) begin
          chk("unexpected_ready", 32'(req_ready), 32'd0);
        end else begin
          e = exp_hs.pop_front();
          chk("handshake {ready,grant,busy,valid,data}",
              {17'd0, req_ready, grant_idx, busy, req_valid[e[9:8]], req_data[8*e[9:8] +: 8]},
              {17'd0, 4'(1 << e[9:8]), e[9:8], 1'b1, 1'b1, e[7:0]});
        end
      end
    end
  end

  // Line monitor: decodes txd frames
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (txd == 1'b0) begin
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          b[k] = txd;
          repeat (CPB) @(negedge clk);
        end
        if (exp_line.size() == 0) begin
          chk("unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
        end else begin
          chk("line_frame {stop,byte}", {23'd0, txd, b}, {23'd0, 1'b1, exp_line.pop_front()});
        end
      end
    end
  end

  // Hand pkt[] to the requesters named in mask (all valid together) and
  // predict service order by scanning from the model pointer.
  task automatic issue(input logic [NUM_REQ-1:0] mask);
    int unsigned p;
    int unsigned i;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (mask[r]) begin
        for (int j = 0; j < pkt[r].size(); j++)
          rq[r].push_back({(j == pkt[r].size() - 1), pkt[r][j]});
        stall[r] = 0;
      end
    end
    p = m_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      i = (p + k) % NUM_REQ;
      if (mask[i]) begin
`ifdef UART_ARB_CHAN_HDR_EN
        exp_line.push_back({4'hA, 4'(i)});
`endif
        for (int j = 0; j < pkt[i].size(); j++) begin
          exp_line.push_back(pkt[i][j]);
          exp_hs.push_back({2'(i), pkt[i][j]});
        end
        m_ptr = (i + 1) % NUM_REQ;
      end
    end
    for (int r = 0; r < NUM_REQ; r++) pkt[r].delete();
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (exp_line.size() == 0 && exp_hs.size() == 0 && !busy && !tx_active &&
          rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0)
        done = 1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    int t0, t1;
    bit ok;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_tx_start", 32'(tx_start), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_grant", 32'(grant_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request, latency to first tx_start
    pkt[2].push_back(8'h55);
    pkt[2].push_back(8'hC3);
    issue(4'b0100);
    t0 = -1; t1 = -1;
    for (int c = 0; c < 20 && t1 < 0; c++) begin
      @(negedge clk);
      if (t0 < 0 && req_valid[2]) t0 = c;
      if (tx_start) t1 = c;
    end
    chk("start_latency", 32'(t1 - t0), 32'd2);
    wait_idle("single_done");

    // Contention, two rounds (pointer now 3)
    for (int r = 0; r < 2; r++) begin
      for (int q = 0; q < NUM_REQ; q++)
        if (q != 2) begin
          pkt[q].push_back(8'($urandom));
          pkt[q].push_back(8'($urandom));
        end
      issue(4'b1011);
      wait_idle("contention_done");
    end

    // 8 back-to-back bytes through the cleanup cycle
    for (int j = 0; j < 8; j++) pkt[0].push_back(8'($urandom));
    issue(4'b0001);
    wait_idle("b2b_done");

    // Randomized rounds (lengths 1..4, random subsets, random owner stalls)
    for (int r = 0; r < 20; r++) begin
      logic [NUM_REQ-1:0] m;
      m = NUM_REQ'($urandom_range(1, 15));
      for (int q = 0; q < NUM_REQ; q++)
        if (m[q]) begin
          int unsigned len;
          len = $urandom_range(1, 4);
          for (int unsigned j = 0; j < len; j++) pkt[q].push_back(8'($urandom));
        end
      issue(m);
      wait_idle("random_done");
    end

    // Reset during data bit 3 of the first payload frame
    rq[2].push_back({1'b0, 8'h3C});
    rq[2].push_back({1'b0, 8'h99});
    rq[2].push_back({1'b1, 8'h66});
    stall[2] = 0;
`ifdef UART_ARB_CHAN_HDR_EN
    exp_line.push_back({4'hA, 4'd2});
`endif
    exp_line.push_back(8'h3C);
    exp_hs.push_back({2'd2, 8'h3C});
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (exp_hs.size() == 0) ok = 1;
    end
    chk("rst_first_handshake", 32'(ok), 32'd1);
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (tx_active) ok = 1;
    end
    chk("rst_frame_started", 32'(ok), 32'd1);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    rq[2].delete();
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    rst = 1'b0;
    m_ptr = 0;
    pkt[1].push_back(8'hE7);
    pkt[1].push_back(8'h18);
    issue(4'b0010);
    ok = 1;
    for (int c = 0; c < 200 && tx_active; c++) begin
      @(negedge clk);
      if (tx_active && (busy || tx_start)) ok = 0;
    end
    chk("holdoff_while_active", 32'(ok), 32'd1);
    wait_idle("post_reset_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
